// File: rtl/hld_phase_sequencer.sv
// Traffic-light phase sequencer: NS green -> NS yellow -> EW green -> EW yellow,
// with request-driven green dwell bounded by GREEN_MIN/GREEN_MAX ticks.
module hld_phase_sequencer #(
    parameter int GREEN_MIN  = 20,
    parameter int GREEN_MAX  = 60,
    parameter int YELLOW_LEN = 5,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_en,
    input  logic       ew_req,
    input  logic       ns_req,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic [1:0] phase,
    output logic       phase_start
);

    localparam logic [1:0] ST_NS_G = 2'd0;
    localparam logic [1:0] ST_NS_Y = 2'd1;
    localparam logic [1:0] ST_EW_G = 2'd2;
    localparam logic [1:0] ST_EW_Y = 2'd3;

    localparam logic [3:0] CODE_NS_G = 4'b0000;
    localparam logic [3:0] CODE_NS_Y = 4'b0101;
    localparam logic [3:0] CODE_EW_G = 4'b1010;
    localparam logic [3:0] CODE_EW_Y = 4'b1100;

    localparam logic [CNT_W-1:0] L_GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] L_GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] L_Y_LAST    = CNT_W'(YELLOW_LEN - 1);
    localparam logic [CNT_W-1:0] L_ONE       = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_abcd;
    logic             r_phase_start;

    logic             w_cross_req;
    logic             w_green_done;
    logic             w_yellow_done;
    logic             w_advance;
    logic [1:0]       w_next_state;
    logic [3:0]       w_next_code;

    // Only the request of the direction currently held at red can end a green.
    assign w_cross_req   = (r_state == ST_NS_G) ? ew_req : ns_req;
    assign w_green_done  = ((r_cnt >= L_GMIN_LAST) && w_cross_req) || (r_cnt == L_GMAX_LAST);
    assign w_yellow_done = (r_cnt == L_Y_LAST);

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_advance    = 1'b0;
        w_next_state = r_state;
        case (r_state)
            ST_NS_G: if (w_green_done)  begin w_advance = 1'b1; w_next_state = ST_NS_Y; end
            ST_NS_Y: if (w_yellow_done) begin w_advance = 1'b1; w_next_state = ST_EW_G; end
            ST_EW_G: if (w_green_done)  begin w_advance = 1'b1; w_next_state = ST_EW_Y; end
            default: if (w_yellow_done) begin w_advance = 1'b1; w_next_state = ST_NS_G; end
        endcase
    end

    always_comb begin
        w_next_code = CODE_NS_G;
        case (w_next_state)
            ST_NS_Y: w_next_code = CODE_NS_Y;
            ST_EW_G: w_next_code = CODE_EW_G;
            ST_EW_Y: w_next_code = CODE_EW_Y;
            default: w_next_code = CODE_NS_G;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values; reset is synchronous, checked inside the clocked block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_NS_G;
            r_cnt         <= '0;
            r_abcd        <= CODE_NS_G;
            r_phase_start <= 1'b0;
        end else if (tick_en) begin
            r_state       <= w_next_state;
            r_abcd        <= w_next_code;
            r_phase_start <= w_advance;
            r_cnt         <= w_advance ? '0 : r_cnt + L_ONE;
        end else begin
            r_phase_start <= 1'b0;
        end
    end

    assign {A, B, C, D}  = r_abcd;
    assign phase         = r_state;
    assign phase_start   = r_phase_start;

endmodule

// File: tb/tb_hld_phase_sequencer.sv
// Scoreboard bench for hld_phase_sequencer: a tick-counting reference model
// pushes the expected outputs per edge; scenario tasks pop and compare.
module tb_hld_phase_sequencer;

    localparam int GMIN = 3;
    localparam int GMAX = 6;
    localparam int YLEN = 2;

    typedef struct packed {
        logic [3:0] abcd;
        logic [1:0] phase;
        logic       ps;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_en = 1'b0;
    logic       ew_req = 1'b0;
    logic       ns_req = 1'b0;
    logic       A, B, C, D;
    logic [1:0] phase;
    logic       phase_start;

    int   errors = 0;
    int   checks = 0;
    obs_t sb[$];

    int   m_phase = 0;
    int   m_elapsed = 0;
    logic m_ps = 1'b0;

    hld_phase_sequencer #(
        .GREEN_MIN (GMIN),
        .GREEN_MAX (GMAX),
        .YELLOW_LEN(YLEN),
        .CNT_W     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_en    (tick_en),
        .ew_req     (ew_req),
        .ns_req     (ns_req),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .phase      (phase),
        .phase_start(phase_start)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] code_of(input int p);
        case (p)
            1:       return 4'b0101;
            2:       return 4'b1010;
            3:       return 4'b1100;
            default: return 4'b0000;
        endcase
    endfunction

    // Drive one cycle of inputs, advance the model by the coming edge, push its prediction.
    task automatic drive(input logic t, input logic ew, input logic ns, input logic rs);
        int  done_ticks;
        logic leave;
        @(negedge clk);
        tick_en = t; ew_req = ew; ns_req = ns; rst_n = rs;
        if (!rs) begin
            m_phase = 0; m_elapsed = 0; m_ps = 1'b0;
        end else if (t) begin
            done_ticks = m_elapsed + 1;
            if (m_phase == 0)      leave = (done_ticks >= GMIN && ew) || done_ticks == GMAX;
            else if (m_phase == 2) leave = (done_ticks >= GMIN && ns) || done_ticks == GMAX;
            else                   leave = (done_ticks == YLEN);
            if (leave) begin
                m_phase = (m_phase + 1) % 4; m_elapsed = 0; m_ps = 1'b1;
            end else begin
                m_elapsed = done_ticks; m_ps = 1'b0;
            end
        end else begin
            m_ps = 1'b0;
        end
        sb.push_back('{abcd: code_of(m_phase), phase: 2'(m_phase), ps: m_ps});
    endtask

    // Wait for the edge, sample the DUT 1 ns later and pop the matching prediction.
    task automatic observe(output obs_t got, output obs_t exp);
        @(posedge clk);
        #1;
        got = '{abcd: {A, B, C, D}, phase: phase, ps: phase_start};
        if (sb.size() == 0) exp = 'x;
        else exp = sb.pop_front();
    endtask

    task automatic test_reset();
        obs_t g, e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            observe(g, e);
            checks++;
            if (g !== 7'b0000_00_0 || g !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got abcd=%b phase=%0d ps=%b, want abcd=0000 phase=0 ps=0", i, g.abcd, g.phase, g.ps);
            end
        end
    endtask

    task automatic test_request_min();
        obs_t g, e;
        logic [3:0] want_code [5];
        logic       want_ps   [5];
        want_code = '{4'b0000, 4'b0000, 4'b0101, 4'b0101, 4'b1010};
        want_ps   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1);
            observe(g, e);
            checks++;
            if (g !== e || g.abcd !== want_code[i] || g.ps !== want_ps[i]) begin
                errors++;
                $display("FAIL request_min[%0d]: got abcd=%b ps=%b, want abcd=%b ps=%b", i, g.abcd, g.ps, want_code[i], want_ps[i]);
            end
        end
    endtask

    task automatic test_fixed_period();
        obs_t g, e;
        int first_ns = -1, second_ns = -1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        observe(g, e);
        for (int i = 1; i <= 34; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1);
            observe(g, e);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL no_req[%0d]: got abcd=%b phase=%0d ps=%b, want abcd=%b phase=%0d ps=%b", i, g.abcd, g.phase, g.ps, e.abcd, e.phase, e.ps);
            end
            if (g.ps === 1'b1 && g.phase === 2'd0) begin
                if (first_ns < 0) first_ns = i;
                else if (second_ns < 0) second_ns = i;
            end
        end
        checks++;
        if (first_ns != 16 || second_ns - first_ns != 16) begin
            errors++;
            $display("FAIL period: got NS_G re-entry at %0d and %0d, want 16 and 32", first_ns, second_ns);
        end
    endtask

    task automatic test_alt_tick();
        obs_t g, e;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        observe(g, e);
        for (int i = 0; i < 24; i++) begin
            drive(i[0] == 1'b0, 1'b1, 1'b0, 1'b1);
            observe(g, e);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL alt_tick[%0d]: got abcd=%b phase=%0d ps=%b, want abcd=%b phase=%0d ps=%b", i, g.abcd, g.phase, g.ps, e.abcd, e.phase, e.ps);
            end
        end
    endtask

    task automatic test_reset_mid_phase();
        obs_t g, e;
        int guard = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        observe(g, e);
        while (!(m_phase == 3 && m_elapsed == 1) && guard < 40) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1);
            observe(g, e);
            guard++;
        end
        checks++;
        if (g !== e || g.abcd !== 4'b1100) begin
            errors++;
            $display("FAIL mid_reset_setup: got abcd=%b after %0d edges, want abcd=1100", g.abcd, guard);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        observe(g, e);
        checks++;
        if (g !== e || g !== 7'b0000_00_0) begin
            errors++;
            $display("FAIL mid_reset: got abcd=%b phase=%0d ps=%b, want abcd=0000 phase=0 ps=0", g.abcd, g.phase, g.ps);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1);
            observe(g, e);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL after_reset[%0d]: got abcd=%b phase=%0d ps=%b, want abcd=%b phase=%0d ps=%b", i, g.abcd, g.phase, g.ps, e.abcd, e.phase, e.ps);
            end
        end
    endtask

    task automatic test_req_pulse();
        obs_t g, e;
        int ns_ticks = 0;
        logic left = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        observe(g, e);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, i == 0, 1'b0, 1'b1);
            observe(g, e);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL req_pulse[%0d]: got abcd=%b phase=%0d ps=%b, want abcd=%b phase=%0d ps=%b", i, g.abcd, g.phase, g.ps, e.abcd, e.phase, e.ps);
            end
            if (!left) ns_ticks++;
            if (g.phase !== 2'd0) left = 1'b1;
        end
        checks++;
        if (ns_ticks != GMAX) begin
            errors++;
            $display("FAIL pulse_dwell: got NS_G dwell=%0d ticks, want %0d", ns_ticks, GMAX);
        end
    endtask

    task automatic test_both_requests();
        obs_t g, e;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        observe(g, e);
        for (int i = 0; i < 22; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1);
            observe(g, e);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL both_req[%0d]: got abcd=%b phase=%0d ps=%b, want abcd=%b phase=%0d ps=%b", i, g.abcd, g.phase, g.ps, e.abcd, e.phase, e.ps);
            end
        end
    endtask

    initial begin
        test_reset();
        test_request_min();
        test_fixed_period();
        test_alt_tick();
        test_reset_mid_phase();
        test_req_pulse();
        test_both_requests();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
